vga_scan_driver: RTL and testbench

Generates 640x480@60 Hz VGA timing from the 100 MHz board clock. Drives the pixel address bus (ADDRH/ADDRY) into the game colour logic and samples that logic's 12-bit colour back. Emits gated RGB plus HS/VS to the BASYS3 VGA connector. It is the display-side end of the address/colour interface the game controller answers.

---
 rtl/vga_scan_driver.sv | 122 ++++++++++++
 tb/tb_vga_scan_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_driver.sv
// VGA 640x480@60 scan generator: pixel divider, h/v counters, visible-area addresses,
// colour capture and HS/VS, with colour and syncs aligned one pixel behind the address.
module vga_scan_driver #(
  parameter int CLK_DIV     = 4,
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] COLOUR_IN,
  output logic [9:0]  ADDRH,
  output logic [9:0]  ADDRY,
  output logic        DISPLAY_EN,
  output logic        PIX_EN,
  output logic        FRAME_START,
  output logic        HS,
  output logic        VS,
  output logic [11:0] COLOUR_OUT
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  // Counters share the 10-bit width of the address ports, so totals must stay below 1024.
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]       V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]       HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]       HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]       VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]       VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic             SYNC_ON  = 1'(SYNC_ACTIVE);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic [9:0]       addrh_q, addrh_d;
  logic [9:0]       addry_q, addry_d;
  logic             disp_en_q, disp_en_d;
  logic [11:0]      colour_q, colour_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             pix_en;
  logic             h_wrap;
  logic             vis_d;

  always_comb begin
    pix_en   = (div_q == DIV_LAST);
    h_wrap   = (hcount_q == H_LAST);
    div_d    = pix_en ? '0 : div_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en) begin
      hcount_d = h_wrap ? '0 : hcount_q + 10'd1;
      if (h_wrap) begin
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end
    end

    // Addresses follow the next counter values so they change on the pixel edge itself
    // and hold for the full pixel period.
    vis_d     = (hcount_d < H_VIS) && (vcount_d < V_VIS);
    addrh_d   = vis_d ? hcount_d : '0;
    addry_d   = vis_d ? vcount_d : '0;
    disp_en_d = vis_d;

    colour_d = colour_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    if (pix_en) begin
      // Everything captured here describes the pixel that is just ending.
      colour_d = disp_en_q ? COLOUR_IN : 12'h000;
      hs_d     = (hcount_q >= HS_START && hcount_q < HS_END) ? SYNC_ON : ~SYNC_ON;
      vs_d     = (vcount_q >= VS_START && vcount_q < VS_END) ? SYNC_ON : ~SYNC_ON;
    end

    FRAME_START = pix_en && h_wrap && (vcount_q == V_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q     <= '0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      addrh_q   <= '0;
      addry_q   <= '0;
      disp_en_q <= 1'b0;
      colour_q  <= '0;
      hs_q      <= ~SYNC_ON;
      vs_q      <= ~SYNC_ON;
    end else begin
      div_q     <= div_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      addrh_q   <= addrh_d;
      addry_q   <= addry_d;
      disp_en_q <= disp_en_d;
      colour_q  <= colour_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign PIX_EN     = pix_en;
  assign ADDRH      = addrh_q;
  assign ADDRY      = addry_q;
  assign DISPLAY_EN = disp_en_q;
  assign COLOUR_OUT = colour_q;
  assign HS         = hs_q;
  assign VS         = vs_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench for vga_scan_driver: full horizontal timing, vertical timing shortened to
// an 8-line frame (4 visible, front 1, sync 2, back 1) so two frames fit in a short run.
module tb_vga_scan_driver;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [11:0] COLOUR_IN;
  logic [9:0]  ADDRH, ADDRY;
  logic        DISPLAY_EN, PIX_EN, FRAME_START, HS, VS;
  logic [11:0] COLOUR_OUT;

  logic        game_mode = 1'b0;
  logic [11:0] game_colour = 12'h000;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Phase A bookkeeping
  logic hs_prev = 1'b1, vs_prev = 1'b1;
  int hs_fall1 = -1, hs_fall2 = -1, hs_rise1 = -1;
  int vs_fall1 = -1, vs_fall2 = -1, vs_rise1 = -1;
  int fs1 = -1, fs2 = -1, fs_cnt = 0;
  int max_addry = 0, max_addrh = 0;
  int addr_bad = 0, gate_bad = 0, align_bad = 0;
  int first_vis = -1, last_vis = -1;

  vga_scan_driver #(
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .COLOUR_IN(COLOUR_IN),
    .ADDRH(ADDRH), .ADDRY(ADDRY), .DISPLAY_EN(DISPLAY_EN), .PIX_EN(PIX_EN),
    .FRAME_START(FRAME_START), .HS(HS), .VS(VS), .COLOUR_OUT(COLOUR_OUT)
  );

  always #5 CLK = ~CLK;

  // Game-logic model: colour registered one CLK after the address it answers.
  always @(posedge CLK) game_colour <= {2'b00, ADDRH};
  assign COLOUR_IN = game_mode ? game_colour : 12'hABC;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
  endtask

  task automatic sample_a();
    int p, g, pg;
    logic [11:0] exp_c;
    if (HS === 1'b0 && hs_prev === 1'b1) begin
      if (hs_fall1 < 0) hs_fall1 = cyc; else if (hs_fall2 < 0) hs_fall2 = cyc;
    end
    if (HS === 1'b1 && hs_prev === 1'b0 && hs_rise1 < 0) hs_rise1 = cyc;
    hs_prev = HS;
    if (VS === 1'b0 && vs_prev === 1'b1) begin
      if (vs_fall1 < 0) vs_fall1 = cyc; else if (vs_fall2 < 0) vs_fall2 = cyc;
    end
    if (VS === 1'b1 && vs_prev === 1'b0 && vs_rise1 < 0) vs_rise1 = cyc;
    vs_prev = VS;
    if (FRAME_START === 1'b1) begin
      fs_cnt++;
      if (fs1 < 0) fs1 = cyc; else if (fs2 < 0) fs2 = cyc;
    end
    if (DISPLAY_EN === 1'b1) begin
      if (int'(ADDRY) > max_addry) max_addry = int'(ADDRY);
      if (int'(ADDRH) > max_addrh) max_addrh = int'(ADDRH);
    end
    if (cyc < 3200) begin
      p = cyc / 4;
      if (ADDRH !== 10'((p < 640) ? p : 0) || ADDRY !== 10'd0 ||
          (cyc > 0 && DISPLAY_EN !== (p < 640)))
        addr_bad++;
    end
    g = cyc / 4;
    exp_c = 12'h000;
    if (g > 0) begin
      pg = g - 1;
      if ((pg % 800) < 640 && ((pg / 800) % 8) < 4) exp_c = 12'hABC;
    end
    if (COLOUR_OUT !== exp_c) gate_bad++;
  endtask

  initial begin
    int n;
    int p;
    int exp_a;

    // Reset values
    RESET = 1'b1;
    repeat (5) @(negedge CLK);
    check("rst_addrh", ADDRH, 0);
    check("rst_addry", ADDRY, 0);
    check("rst_colour", COLOUR_OUT, 0);
    check("rst_hs", HS, 1);
    check("rst_vs", VS, 1);
    check("rst_pix_en", PIX_EN, 0);
    check("rst_frame_start", FRAME_START, 0);
    check("rst_display_en", DISPLAY_EN, 0);

    // Release; this negedge is the first cycle (divider 0) of pixel (0,0).
    RESET = 1'b0;
    cyc = 0;
    n = 1;
    while (PIX_EN !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("first_pix_en_cycle", n, 4);

    // Phase A: two frames with constant colour, measured from cycle 0.
    // Skipped cycles already happened; restart bookkeeping by replaying from a fresh reset.
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    cyc = 0;
    sample_a();
    while (cyc < 51299) begin
      step();
      sample_a();
    end
    check("hs_first_fall", hs_fall1, 2628);
    check("hs_low_width", hs_rise1 - hs_fall1, 384);
    check("hs_period", hs_fall2 - hs_fall1, 3200);
    check("vs_first_fall", vs_fall1, 16004);
    check("vs_low_width", vs_rise1 - vs_fall1, 6400);
    check("vs_period", vs_fall2 - vs_fall1, 25600);
    check("frame_start_first", fs1, 25599);
    check("frame_start_period", fs2 - fs1, 25600);
    check("frame_start_count", fs_cnt, 2);
    check("max_addry", max_addry, 3);
    check("max_addrh", max_addrh, 639);
    check("addr_sweep_bad", addr_bad, 0);
    check("colour_gate_bad", gate_bad, 0);

    // Phase B: game-logic model, check line 1 of the next frame.
    game_mode = 1'b1;
    while (cyc < 57599) begin
      step();
      if (cyc >= 54400) begin
        p = (cyc - 54400) / 4;
        exp_a = (p >= 1 && p <= 640) ? p - 1 : 0;
        if (COLOUR_OUT !== 12'(exp_a)) align_bad++;
        if (cyc == 54404) first_vis = int'(COLOUR_OUT);
        if (cyc == 54400 + 4 * 640) last_vis = int'(COLOUR_OUT);
      end
    end
    check("align_bad", align_bad, 0);
    check("first_vis_colour", first_vis, 12'h000);
    check("last_vis_colour", last_vis, 12'h27F);

    // Phase C: reset in the middle of line 2, pixel 300.
    while (cyc < 58800) step();
    check("pre_reset_addrh", ADDRH, 300);
    check("pre_reset_addry", ADDRY, 2);
    RESET = 1'b1;
    @(negedge CLK);
    check("mid_rst_addrh", ADDRH, 0);
    check("mid_rst_addry", ADDRY, 0);
    check("mid_rst_hs", HS, 1);
    check("mid_rst_vs", VS, 1);
    check("mid_rst_display_en", DISPLAY_EN, 0);
    check("mid_rst_colour", COLOUR_OUT, 0);
    RESET = 1'b0;
    cyc = 0;
    while (FRAME_START !== 1'b1 && cyc < 30000) step();
    check("frame_after_reset", cyc, 25599);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
